// File: rtl/trdb_pkg.sv
// Shared trace-encoder types used by the resync timer.
package trdb_pkg;

  // What the resync timer counts: prescaled clock cycles or emitted packets.
  typedef enum logic {
    CYCLE_MODE  = 1'b0,
    PACKET_MODE = 1'b1
  } resync_mode_e;

  // Resync timer control states.
  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    COUNT    = 2'd1,
    PENDING  = 2'd2
  } resync_state_e;

endpackage

// File: rtl/trdb_resync_prescaler.sv
// Cycle-mode prescaler: emits one tick every (prescale_i + 1) enabled cycles.
// clr_i has priority over counting and returns the divider to 0.
module trdb_resync_prescaler #(
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic                  clr_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  output logic                  tick_o
);

  logic [PRESCALE_W-1:0] cnt_q;
  logic [PRESCALE_W-1:0] cnt_d;

  assign tick_o = en_i && (cnt_q == prescale_i);

  // Next divider value: clear, wrap on tick, otherwise advance while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (tick_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + PRESCALE_W'(1);
    end
  end

  // Divider register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/trdb_resync_timer.sv
// Programmable resync timer: counts prescaled cycles or packets against a
// runtime threshold and holds a sticky request until the emitter acks it.
module trdb_resync_timer
  import trdb_pkg::*;
#(
  parameter int unsigned  CNT_W        = 16,
  parameter int unsigned  PRESCALE_W   = 8,
  parameter resync_mode_e DEFAULT_MODE = CYCLE_MODE
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  trace_enabled_i,
  input  logic                  mode_i,
  input  logic [CNT_W-1:0]      threshold_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  input  logic                  packet_emitted_i,
  input  logic                  resync_rst_i,
  output logic                  resync_max_o,
  output logic [CNT_W-1:0]      count_o
);

  resync_state_e    state_q;
  resync_state_e    state_d;
  resync_mode_e     mode_q;
  resync_mode_e     mode_d;
  logic [CNT_W-1:0] counter_q;
  logic [CNT_W-1:0] counter_d;

  logic             mode_change;
  logic             presc_en;
  logic             presc_clr;
  logic             presc_tick;
  logic             event_hit;
  logic [CNT_W:0]   count_inc;
  logic             threshold_hit;

  // Saturating increment: the counter sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign mode_d      = resync_mode_e'(mode_i);
  assign mode_change = (mode_d != mode_q);

  // The divider only runs while counting cycles; any ack, mode change or
  // disable restarts it so a fresh interval begins from zero.
  assign presc_en  = (state_q == COUNT) && (mode_q == CYCLE_MODE);
  assign presc_clr = !trace_enabled_i || resync_rst_i || mode_change;

  trdb_resync_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .en_i       (presc_en),
    .clr_i      (presc_clr),
    .prescale_i (prescale_i),
    .tick_o     (presc_tick)
  );

  // One extra bit so a saturated counter still compares as reaching any threshold.
  assign count_inc     = {1'b0, counter_q} + (CNT_W + 1)'(1);
  assign threshold_hit = (threshold_i != '0) && (count_inc >= {1'b0, threshold_i});

  // Counting event; an ack or mode change in the same cycle drops it.
  always_comb begin
    event_hit = 1'b0;
    if ((state_q == COUNT) && trace_enabled_i && !resync_rst_i && !mode_change) begin
      event_hit = (mode_q == PACKET_MODE) ? packet_emitted_i : presc_tick;
    end
  end

  // FSM next state and event counter update.
  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    if (!trace_enabled_i) begin
      state_d   = DISABLED;
      counter_d = '0;
    end else begin
      unique case (state_q)
        DISABLED: begin
          state_d   = COUNT;
          counter_d = '0;
        end
        COUNT: begin
          if (resync_rst_i || mode_change) begin
            counter_d = '0;
          end else if (event_hit) begin
            counter_d = sat_inc(counter_q);
            if (threshold_hit) begin
              state_d = PENDING;
            end
          end
        end
        PENDING: begin
          if (resync_rst_i) begin
            state_d   = COUNT;
            counter_d = '0;
          end else if (mode_change) begin
            counter_d = '0;
          end
        end
        default: begin
          state_d   = DISABLED;
          counter_d = '0;
        end
      endcase
    end
  end

  // State, mode and counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= DISABLED;
      mode_q    <= DEFAULT_MODE;
      counter_q <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      counter_q <= counter_d;
    end
  end

  assign resync_max_o = (state_q == PENDING);
  assign count_o      = counter_q;

endmodule

// File: tb/tb_trdb_resync_timer.sv
// Bench for trdb_resync_timer: vector table, directed corner sequences and
// randomized traffic against a behavioural model.
module tb_trdb_resync_timer;

  localparam int          CNT_W      = 16;
  localparam int          PRESCALE_W = 8;
  localparam int unsigned CMAX       = (1 << CNT_W) - 1;

  logic                  clk = 1'b0;
  logic                  rst_ni = 1'b0;
  logic                  trace_enabled_i = 1'b0;
  logic                  mode_i = 1'b0;
  logic [CNT_W-1:0]      threshold_i = '0;
  logic [PRESCALE_W-1:0] prescale_i = '0;
  logic                  packet_emitted_i = 1'b0;
  logic                  resync_rst_i = 1'b0;
  logic                  resync_max_o;
  logic [CNT_W-1:0]      count_o;

  always #5 clk = ~clk;

  trdb_resync_timer #(
    .CNT_W      (CNT_W),
    .PRESCALE_W (PRESCALE_W)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .trace_enabled_i  (trace_enabled_i),
    .mode_i           (mode_i),
    .threshold_i      (threshold_i),
    .prescale_i       (prescale_i),
    .packet_emitted_i (packet_emitted_i),
    .resync_rst_i     (resync_rst_i),
    .resync_max_o     (resync_max_o),
    .count_o          (count_o)
  );

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model: enabled flag, request flag, plain integer counters.
  bit          m_on;
  bit          m_pend;
  int unsigned m_cnt;
  int unsigned m_pre;
  bit          m_mode;

  function automatic void model_reset();
    m_on = 0; m_pend = 0; m_cnt = 0; m_pre = 0; m_mode = 0;
  endfunction

  function automatic void model_step();
    bit ev;
    if (!trace_enabled_i) begin
      m_on = 0; m_pend = 0; m_cnt = 0; m_pre = 0;
    end else if (!m_on) begin
      m_on = 1; m_cnt = 0; m_pre = 0;
    end else if (resync_rst_i || (mode_i != m_mode)) begin
      m_cnt = 0; m_pre = 0;
      if (resync_rst_i) m_pend = 0;
    end else if (!m_pend) begin
      if (m_mode) begin
        ev = packet_emitted_i;
      end else begin
        ev = (m_pre == prescale_i);
        m_pre = ev ? 0 : (m_pre + 1) % (1 << PRESCALE_W);
      end
      if (ev) begin
        if (threshold_i != 0 && m_cnt + 1 >= threshold_i) m_pend = 1;
        if (m_cnt < CMAX) m_cnt = m_cnt + 1;
      end
    end
    m_mode = mode_i;
  endfunction

  task automatic check(input string name, input logic act_max, input logic [CNT_W-1:0] act_cnt,
                       input logic exp_max, input logic [CNT_W-1:0] exp_cnt);
    vectors++;
    if (act_max !== exp_max || act_cnt !== exp_cnt) begin
      miscompares++;
      $display("FAIL %s: got resync_max_o=%0b count_o=%0d, expected %0b / %0d",
               name, act_max, act_cnt, exp_max, exp_cnt);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input bit cmp, input string name);
    model_step();
    @(posedge clk);
    #1;
    if (cmp) check(name, resync_max_o, count_o, m_pend, CNT_W'(m_cnt));
  endtask

  task automatic do_reset();
    trace_enabled_i = 0; mode_i = 0; threshold_i = '0; prescale_i = '0;
    packet_emitted_i = 0; resync_rst_i = 0;
    rst_ni = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset", resync_max_o, count_o, 1'b0, '0);
    @(negedge clk);
    rst_ni = 1;
    model_reset();
  endtask

  typedef struct {
    bit               en;
    bit               mode;
    logic [CNT_W-1:0] thr;
    logic [7:0]       presc;
    bit               pkt;
    bit               rst;
    bit               exp_max;
    logic [CNT_W-1:0] exp_cnt;
  } vec_t;

  vec_t tbl[25];

  initial begin
    int rise;
    int held;
    bit seen_max;

    //          en mode thr presc pkt rst  max cnt
    tbl[0]  = '{1, 0, 16'd5, 8'd0, 0, 0, 0, 16'd0};
    tbl[1]  = '{1, 0, 16'd5, 8'd0, 0, 0, 0, 16'd1};
    tbl[2]  = '{1, 0, 16'd5, 8'd0, 0, 0, 0, 16'd2};
    tbl[3]  = '{1, 0, 16'd5, 8'd0, 0, 0, 0, 16'd3};
    tbl[4]  = '{1, 0, 16'd5, 8'd0, 0, 0, 0, 16'd4};
    tbl[5]  = '{1, 0, 16'd5, 8'd0, 0, 0, 1, 16'd5};
    tbl[6]  = '{1, 0, 16'd5, 8'd0, 0, 0, 1, 16'd5};
    tbl[7]  = '{1, 0, 16'd5, 8'd0, 0, 0, 1, 16'd5};
    tbl[8]  = '{1, 0, 16'd5, 8'd0, 0, 1, 0, 16'd0};
    tbl[9]  = '{1, 0, 16'd5, 8'd0, 0, 0, 0, 16'd1};
    tbl[10] = '{1, 1, 16'd3, 8'd0, 0, 0, 0, 16'd0};
    tbl[11] = '{1, 1, 16'd3, 8'd0, 1, 0, 0, 16'd1};
    tbl[12] = '{1, 1, 16'd3, 8'd0, 0, 0, 0, 16'd1};
    tbl[13] = '{1, 1, 16'd3, 8'd0, 1, 0, 0, 16'd2};
    tbl[14] = '{1, 1, 16'd3, 8'd0, 1, 1, 0, 16'd0};
    tbl[15] = '{1, 1, 16'd3, 8'd0, 1, 0, 0, 16'd1};
    tbl[16] = '{1, 1, 16'd3, 8'd0, 1, 0, 0, 16'd2};
    tbl[17] = '{1, 1, 16'd1, 8'd0, 0, 0, 0, 16'd2};
    tbl[18] = '{1, 1, 16'd1, 8'd0, 1, 0, 1, 16'd3};
    tbl[19] = '{1, 1, 16'd0, 8'd0, 1, 0, 1, 16'd3};
    tbl[20] = '{1, 0, 16'd0, 8'd0, 0, 0, 1, 16'd0};
    tbl[21] = '{0, 0, 16'd0, 8'd0, 0, 0, 0, 16'd0};
    tbl[22] = '{0, 0, 16'd0, 8'd0, 0, 0, 0, 16'd0};
    tbl[23] = '{1, 0, 16'd0, 8'd0, 0, 0, 0, 16'd0};
    tbl[24] = '{1, 0, 16'd0, 8'd0, 0, 0, 0, 16'd1};

    // Vector table
    do_reset();
    for (int i = 0; i < 25; i++) begin
      trace_enabled_i  = tbl[i].en;
      mode_i           = tbl[i].mode;
      threshold_i      = tbl[i].thr;
      prescale_i       = tbl[i].presc;
      packet_emitted_i = tbl[i].pkt;
      resync_rst_i     = tbl[i].rst;
      @(posedge clk);
      #1;
      check($sformatf("table[%0d]", i), resync_max_o, count_o, tbl[i].exp_max, tbl[i].exp_cnt);
    end

    // Cycle mode with prescale 3, threshold 2: request after 1 + 8 cycles
    do_reset();
    trace_enabled_i = 1; mode_i = 0; prescale_i = 8'd3; threshold_i = 16'd2;
    rise = 0;
    for (int n = 1; n <= 20; n++) begin
      step(1, "t2_cycle");
      if (n == 4) check_int("t2_count_before_tick", count_o, 0);
      if (n == 5) check_int("t2_count_after_tick", count_o, 1);
      if (resync_max_o === 1'b1) begin
        rise = n;
        break;
      end
    end
    check_int("t2_rise_cycle", rise, 9);

    // Packet mode, gapped packets, ack 4 cycles after the request
    do_reset();
    trace_enabled_i = 1; mode_i = 1; threshold_i = 16'd3;
    step(1, "t3_enter");
    for (int k = 0; k < 3; k++) begin
      packet_emitted_i = 1; step(1, "t3_pkt");
      packet_emitted_i = 0;
      if (k < 2) step(1, "t3_gap");
    end
    held = (resync_max_o === 1'b1) ? 1 : 0;
    for (int k = 0; k < 3; k++) begin
      step(1, "t3_hold");
      if (resync_max_o === 1'b1) held++;
    end
    check_int("t3_held_cycles", held, 4);
    resync_rst_i = 1; step(1, "t3_ack");
    check("t3_ack_direct", resync_max_o, count_o, 1'b0, '0);
    resync_rst_i = 0;
    packet_emitted_i = 1;
    repeat (3) step(1, "t3_retrigger");
    check("t3_retrigger_direct", resync_max_o, count_o, 1'b1, 16'd3);

    // Disable while pending, then re-enable from zero
    packet_emitted_i = 0;
    trace_enabled_i = 0; step(1, "t5_disable");
    check("t5_disable_direct", resync_max_o, count_o, 1'b0, '0);
    trace_enabled_i = 1; step(1, "t5_reenable");
    packet_emitted_i = 1; step(1, "t5_restart");
    check("t5_restart_direct", resync_max_o, count_o, 1'b0, 16'd1);
    packet_emitted_i = 0;

    // Mode switch clears a count of 7
    do_reset();
    trace_enabled_i = 1; mode_i = 0; prescale_i = 8'd0; threshold_i = 16'd0;
    repeat (8) step(1, "t6_count");
    check_int("t6_count_seven", count_o, 7);
    mode_i = 1; step(1, "t6_mode");
    check("t6_mode_clear", resync_max_o, count_o, 1'b0, '0);

    // Threshold 0 saturates and never requests
    packet_emitted_i = 1;
    seen_max = 0;
    for (int n = 0; n < (1 << CNT_W) + 5; n++) begin
      step(0, "");
      if (resync_max_o !== 1'b0) seen_max = 1;
    end
    check("t6_saturate", resync_max_o, count_o, 1'b0, 16'hFFFF);
    check_int("t6_never_requested", seen_max, 0);

    // Asynchronous reset while pending
    threshold_i = 16'd1;
    step(1, "t6_pend");
    check_int("t6_pend_direct", resync_max_o, 1);
    #2 rst_ni = 0;
    #1;
    check("t6_async_reset", resync_max_o, count_o, 1'b0, '0);
    #2 rst_ni = 1;
    model_reset();

    // Randomized traffic against the model
    trace_enabled_i = 1; mode_i = 0; threshold_i = 16'd4; prescale_i = 8'd1;
    for (int n = 0; n < 3000; n++) begin
      trace_enabled_i  = ($urandom_range(0, 99) < 97);
      if ($urandom_range(0, 99) < 2) mode_i = ~mode_i;
      if ($urandom_range(0, 99) < 5) threshold_i = CNT_W'($urandom_range(0, 6));
      if ($urandom_range(0, 99) < 3) prescale_i = PRESCALE_W'($urandom_range(0, 3));
      packet_emitted_i = $urandom_range(0, 1);
      resync_rst_i     = ($urandom_range(0, 99) < 8);
      step(1, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
